vcb_mod_updown: RTL and testbench

- Parametrised W-bit synchronous up/down counter with runtime-programmable modulus, parallel load, synchronous clear, three count modes (wrap / saturate / one-shot) and clock-enable cascade output.
- Next generation of the team's 4-bit loadable up/down cascade counter: generalised width, arbitrary modulus, terminal-handling modes, done flag.
- Used as a timer or divider tile; CEO feeds the next stage's ce for multi-digit chains.

---
 rtl/vcb_pkg.sv | 23 ++
 rtl/vcb_next_q.sv | 67 ++++++
 rtl/vcb_mod_updown.sv | 89 ++++++++
 tb/tb_vcb_mod_updown.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vcb_pkg.sv
// vcb_pkg: shared definitions for the vcb counter family.
//   - Count-mode encodings (mode input of vcb_mod_updown).
//   - vcb_terminal(): terminal-count predicate, shared so that future
//     cascade blocks agree on what "terminal" means.
package vcb_pkg;

  localparam logic [1:0] VCB_MODE_WRAP    = 2'b00;
  localparam logic [1:0] VCB_MODE_SAT     = 2'b01;
  localparam logic [1:0] VCB_MODE_ONESHOT = 2'b10;

  // Widest counter the predicate supports; callers zero-extend into it.
  localparam int VCB_MAX_W = 32;

  // Up: any value at or beyond modv is terminal, so an out-of-range count
  // (after a load above modv or a lowered modv) still terminates.
  // Down: only zero is terminal.
  function automatic logic vcb_terminal(input logic [VCB_MAX_W-1:0] q,
                                        input logic [VCB_MAX_W-1:0] modv,
                                        input logic                 up);
    return up ? (q >= modv) : (q == '0);
  endfunction

endpackage

// File: rtl/vcb_next_q.sv
// vcb_next_q: combinational next-state for the vcb_mod_updown counter.
// Ports:
//   q, done       current registered count / one-shot flag
//   ce, up        count enable and direction (1 = up)
//   ld, di        synchronous parallel load and its value
//   r             synchronous clear to RST_VAL
//   modv, mode    terminal value and count mode
//   q_nxt,done_nxt values to register on the next rising clk edge
// Priority: ld > r > (ce & !done) count > hold.
module vcb_next_q
  import vcb_pkg::*;
#(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic [W-1:0] q,
  input  logic         done,
  input  logic         ce,
  input  logic         up,
  input  logic         ld,
  input  logic [W-1:0] di,
  input  logic         r,
  input  logic [W-1:0] modv,
  input  logic [1:0]   mode,
  output logic [W-1:0] q_nxt,
  output logic         done_nxt
);

  localparam logic [W-1:0] ONE = W'(1);

  logic term;

  assign term = vcb_terminal(VCB_MAX_W'(q), VCB_MAX_W'(modv), up);

  always_comb begin
    q_nxt    = q;
    done_nxt = done;
    if (ld) begin
      q_nxt    = di;
      done_nxt = 1'b0;
    end else if (r) begin
      q_nxt    = RST_VAL;
      done_nxt = 1'b0;
    end else if (ce && !done) begin
      if (!term) begin
        // Not terminal: up implies q < modv, down implies q > 0, so the
        // step can never overflow or underflow.
        q_nxt = up ? (q + ONE) : (q - ONE);
      end else begin
        case (mode)
          VCB_MODE_SAT: begin
            q_nxt = q;
          end
          VCB_MODE_ONESHOT: begin
            q_nxt    = q;
            done_nxt = 1'b1;
          end
          default: begin
            // Wrap (mode 11 behaves as wrap).
            q_nxt = up ? '0 : modv;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/vcb_mod_updown.sv
// vcb_mod_updown: W-bit up/down counter with programmable modulus (0..modv),
// parallel load, synchronous clear, wrap/saturate/one-shot modes and a
// cascade enable for chaining digits.
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset (Q=RST_VAL, done=0)
//   ce         count enable
//   up         direction, 1 = increment
//   L, di      synchronous parallel load and load value (ignores ce)
//   r          synchronous clear to RST_VAL (ignores ce)
//   modv       terminal value
//   mode       00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   Q          registered count
//   TC         terminal count (combinational)
//   CEO        cascade enable = ce & TC & !done (combinational)
//   done       one-shot completion flag (registered)
// Optional build macro VCB_CAPTURE_EN adds:
//   cap        capture strobe; latches pre-edge Q into Qcap
//   Qcap       captured count, cleared by clr
module vcb_mod_updown
  import vcb_pkg::*;
#(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ce,
  input  logic         up,
  input  logic         L,
  input  logic [W-1:0] di,
  input  logic         r,
  input  logic [W-1:0] modv,
  input  logic [1:0]   mode,
`ifdef VCB_CAPTURE_EN
  input  logic         cap,
  output logic [W-1:0] Qcap,
`endif
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         CEO,
  output logic         done
);

  logic [W-1:0] q_nxt;
  logic         done_nxt;

  vcb_next_q #(
    .W       (W),
    .RST_VAL (RST_VAL)
  ) u_next (
    .q        (Q),
    .done     (done),
    .ce       (ce),
    .up       (up),
    .ld       (L),
    .di       (di),
    .r        (r),
    .modv     (modv),
    .mode     (mode),
    .q_nxt    (q_nxt),
    .done_nxt (done_nxt)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Q    <= RST_VAL;
      done <= 1'b0;
    end else begin
      Q    <= q_nxt;
      done <= done_nxt;
    end
  end

  assign TC  = vcb_terminal(VCB_MAX_W'(Q), VCB_MAX_W'(modv), up);
  assign CEO = ce & TC & ~done;

`ifdef VCB_CAPTURE_EN
  // Samples the same pre-edge Q that the count logic uses on this edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Qcap <= '0;
    end else if (cap) begin
      Qcap <= Q;
    end
  end
`endif

endmodule

// File: tb/tb_vcb_mod_updown.sv
// tb_vcb_mod_updown: directed bench for vcb_mod_updown (W=4, RST_VAL=0).
// A spec-level model tracks the count as a plain integer; a negedge
// process compares Q, TC, CEO, done (and Qcap when VCB_CAPTURE_EN is
// defined) against it every cycle, and literal checks pin the sequences.
module tb_vcb_mod_updown;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         ce = 1'b0, up = 1'b1, L = 1'b0, r = 1'b0;
  logic [W-1:0] di = '0, modv = 4'd9;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] Q;
  logic         TC, CEO, done;
`ifdef VCB_CAPTURE_EN
  logic         cap = 1'b0;
  logic [W-1:0] Qcap;
`endif

  int total = 0;
  int bad   = 0;

  vcb_mod_updown #(.W(W), .RST_VAL(4'd0)) dut (
    .clk  (clk),
    .clr  (clr),
    .ce   (ce),
    .up   (up),
    .L    (L),
    .di   (di),
    .r    (r),
    .modv (modv),
    .mode (mode),
`ifdef VCB_CAPTURE_EN
    .cap  (cap),
    .Qcap (Qcap),
`endif
    .Q    (Q),
    .TC   (TC),
    .CEO  (CEO),
    .done (done)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer count with the rules stated plainly.
  int m_q    = 0;
  int m_done = 0;
  int m_cap  = 0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_q = 0; m_done = 0; m_cap = 0;
    end else begin
      int cur;
      int atend;
      cur = m_q;
`ifdef VCB_CAPTURE_EN
      if (cap) m_cap = cur;
`endif
      atend = up ? (cur >= int'(modv)) : (cur == 0);
      if (L) begin
        m_q = int'(di); m_done = 0;
      end else if (r) begin
        m_q = 0; m_done = 0;
      end else if (ce && m_done == 0) begin
        if (!atend)             m_q = up ? cur + 1 : cur - 1;
        else if (mode == 2'b01) m_q = cur;
        else if (mode == 2'b10) m_done = 1;
        else                    m_q = up ? 0 : int'(modv);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int e_tc;
    e_tc = up ? int'(m_q >= int'(modv)) : int'(m_q == 0);
    chk("model Q", int'(Q), m_q);
    chk("model done", int'(done), m_done);
    chk("model TC", int'(TC), e_tc);
    chk("model CEO", int'(CEO), int'(ce) & e_tc & int'(m_done == 0));
`ifdef VCB_CAPTURE_EN
    chk("model Qcap", int'(Qcap), m_cap);
`endif
  end

  // One clock: returns 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    #3;
    chk("reset Q", int'(Q), 0);
    chk("reset done", int'(done), 0);
    #9 clr = 1'b0;
    tick();

    // Wrap up, modv=9: 0..9,0 ; TC/CEO only at 9
    ce = 1'b1; up = 1'b1; mode = 2'b00; modv = 4'd9;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("wrap up Q", int'(Q), i % 10);
      chk("wrap up TC", int'(TC), int'(i == 9));
      chk("wrap up CEO", int'(CEO), int'(i == 9));
    end
    chk("wrap up done", int'(done), 0);

    // Wrap down from load 2: 2,1,0,9,8
    up = 1'b0; L = 1'b1; di = 4'd2;
    tick();
    chk("load Q", int'(Q), 2);
    L = 1'b0;
    tick(); chk("down Q1", int'(Q), 1);
    tick(); chk("down Q0", int'(Q), 0);
    chk("down TC at 0", int'(TC), 1);
    ce = 1'b0; #1;
    chk("CEO with ce=0", int'(CEO), 0);
    tick(); chk("hold ce=0", int'(Q), 0);
    ce = 1'b1;
    tick(); chk("down wrap Q9", int'(Q), 9);
    tick(); chk("down Q8", int'(Q), 8);

    // Saturate up modv=5 from 3: 4,5,5,5 then down -> 4
    mode = 2'b01; modv = 4'd5; up = 1'b1; L = 1'b1; di = 4'd3;
    tick(); L = 1'b0;
    chk("sat load", int'(Q), 3);
    tick(); chk("sat Q4", int'(Q), 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat Q5", int'(Q), 5);
      chk("sat CEO", int'(CEO), 1);
    end
    up = 1'b0;
    tick(); chk("sat down Q4", int'(Q), 4);

    // One-shot modv=3 up from 0
    mode = 2'b10; modv = 4'd3; up = 1'b1; L = 1'b1; di = 4'd0;
    tick(); L = 1'b0;
    tick(); chk("os Q1", int'(Q), 1);
    tick(); chk("os Q2", int'(Q), 2);
    tick(); chk("os Q3", int'(Q), 3);
    chk("os CEO pulse", int'(CEO), 1);
    chk("os done pre", int'(done), 0);
    tick();
    chk("os done set", int'(done), 1);
    chk("os CEO after", int'(CEO), 0);
    chk("os hold", int'(Q), 3);
    mode = 2'b00;
    tick();
    chk("os done sticky", int'(done), 1);
    chk("os frozen", int'(Q), 3);
    mode = 2'b10; L = 1'b1; di = 4'd0;
    tick(); L = 1'b0;
    chk("os reload done", int'(done), 0);
    tick(); chk("os resume", int'(Q), 1);

    // Lowered modv below Q, then load beats clear
    mode = 2'b00; modv = 4'd9; L = 1'b1; di = 4'd7;
    tick(); L = 1'b0;
    modv = 4'd4;
    tick(); chk("modv lowered wrap", int'(Q), 0);
    L = 1'b1; r = 1'b1; di = 4'd6;
    tick(); chk("load beats clear", int'(Q), 6);
    L = 1'b0;
    tick(); chk("sync clear", int'(Q), 0);
    r = 1'b0;

    // modv=0: stays 0, TC in both directions
    modv = 4'd0;
    tick(); chk("modv0 Q", int'(Q), 0);
    chk("modv0 TC up", int'(TC), 1);
    up = 1'b0; #1;
    chk("modv0 TC down", int'(TC), 1);
    tick(); chk("modv0 Q down", int'(Q), 0);

    // Capture at 5, one-shot done, then mid-cycle clr
    up = 1'b1; modv = 4'd9; L = 1'b1; di = 4'd5;
    tick(); L = 1'b0;
`ifdef VCB_CAPTURE_EN
    cap = 1'b1;
`endif
    tick();
    chk("post cap Q", int'(Q), 6);
`ifdef VCB_CAPTURE_EN
    chk("Qcap", int'(Qcap), 5);
    cap = 1'b0;
`endif
    mode = 2'b10; modv = 4'd6;
    tick(); chk("pre clr done", int'(done), 1);
    #1 clr = 1'b1;
    #1;
    chk("clr Q", int'(Q), 0);
    chk("clr done", int'(done), 0);
`ifdef VCB_CAPTURE_EN
    chk("clr Qcap", int'(Qcap), 0);
`endif
    #2 clr = 1'b0;
    tick();
    chk("after clr Q", int'(Q), 1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
